// File: rtl/booth_mul_seq_pkg.sv
// Shared constants for the Booth multipliers: FSM state codes and Booth step selection.
package booth_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] BOOTH_NOP = 2'd0;
  localparam logic [1:0] BOOTH_ADD = 2'd1;
  localparam logic [1:0] BOOTH_SUB = 2'd2;

  // Radix-2 recoding of the multiplier bit pair {q[i], q[i-1]}.
  function automatic logic [1:0] booth_sel(input logic [1:0] pair);
    case (pair)
      2'b01:   booth_sel = BOOTH_ADD;
      2'b10:   booth_sel = BOOTH_SUB;
      default: booth_sel = BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_mul_seq_if.sv
// Operand and product handshakes of the sequential Booth multiplier.
interface booth_mul_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     M;
  logic [WIDTH-1:0]     Q;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   Z;
  logic                 busy;

  modport slave (
    input  in_valid, M, Q, out_ready,
    output in_ready, out_valid, Z, busy
  );

  modport master (
    output in_valid, M, Q, out_ready,
    input  in_ready, out_valid, Z, busy
  );
endinterface

// File: rtl/booth_mul_seq_step.sv
// One combinational radix-2 Booth add/subtract followed by an arithmetic right shift.
module booth_step
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] qr_i,
  input  logic [WIDTH:0] mr_i,
  output logic [WIDTH:0] a_o,
  output logic [WIDTH:0] qr_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    case (booth_sel(qr_i[1:0]))
      BOOTH_ADD: sum = a_i + mr_i;
      BOOTH_SUB: sum = a_i - mr_i;
      default:   sum = a_i;
    endcase
  end

  assign a_o  = {sum[WIDTH], sum[WIDTH:1]};
  assign qr_o = {sum[0], qr_i[WIDTH:1]};

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed radix-2 Booth multiplier: one Booth step per cycle, WIDTH steps per product.
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  booth_mul_seq_if.slave  mul_io
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH:0]     qr_q, qr_d;
  logic [WIDTH:0]     mr_q, mr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic [WIDTH:0]     a_step, qr_step;
  logic               accept;

  booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a_i  (a_q),
    .qr_i (qr_q),
    .mr_i (mr_q),
    .a_o  (a_step),
    .qr_o (qr_step)
  );

  assign mul_io.in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && mul_io.out_ready);
  assign mul_io.out_valid = (state_q == ST_DONE);
  assign mul_io.busy      = (state_q == ST_RUN);
  assign mul_io.Z         = z_q;
  assign accept           = mul_io.in_valid && mul_io.in_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    qr_d    = qr_q;
    mr_d    = mr_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          a_d     = '0;
          qr_d    = {mul_io.Q, 1'b0};
          mr_d    = {mul_io.M[WIDTH-1], mul_io.M};
          cnt_d   = '0;
          state_d = ST_RUN;
        end else if (state_q == ST_DONE && mul_io.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d   = a_step;
        qr_d  = qr_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = ST_DONE;
          // Top bit of the WIDTH+1 accumulator is a pure sign copy; drop it.
          z_d     = {a_step[WIDTH-1:0], qr_step[WIDTH:1]};
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      qr_q    <= '0;
      mr_q    <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      qr_q    <= qr_d;
      mr_q    <= mr_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: vector table, random products, handshake corner cases.
module tb_booth_mul_seq;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic [2*W-1:0] z;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  booth_mul_seq_if #(.WIDTH(W)) mul_if ();

  booth_mul_seq #(
    .WIDTH (W)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .mul_io (mul_if)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
    longint p;
    p = longint'($signed(m)) * longint'($signed(q));
    return p[2*W-1:0];
  endfunction

  // Wait (bounded) for out_valid after an accept edge; optionally pulse in_valid meanwhile.
  task automatic wait_done(input bit pulse, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!mul_if.out_valid && lat < 100) begin
      if (mul_if.busy) busy_cnt++;
      if (pulse) begin
        mul_if.in_valid = lat[0];
        mul_if.M = 16'd9;
        mul_if.Q = 16'd9;
      end
      tick();
      lat++;
    end
    if (pulse) mul_if.in_valid = 1'b0;
  endtask

  // Start from IDLE, leave the DUT in DONE with the product presented.
  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q,
                        input logic [2*W-1:0] exp, input bit pulse, input string name);
    int lat, busy_cnt;
    check({name, " in_ready"}, 64'(mul_if.in_ready), 64'd1);
    mul_if.M = m;
    mul_if.Q = q;
    mul_if.in_valid = 1'b1;
    tick();
    mul_if.in_valid = 1'b0;
    mul_if.M = '1;
    mul_if.Q = '1;
    wait_done(pulse, lat, busy_cnt);
    check({name, " latency"}, 64'(lat), 64'(W));
    check({name, " busy cycles"}, 64'(busy_cnt), 64'(W));
    check({name, " Z"}, 64'(mul_if.Z), 64'(exp));
  endtask

  // Hold out_ready low for some cycles (product must stay put), then take it.
  task automatic take(input int hold, input logic [2*W-1:0] exp, input string name);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({name, " held out_valid"}, 64'(mul_if.out_valid), 64'd1);
      check({name, " held Z"}, 64'(mul_if.Z), 64'(exp));
    end
    mul_if.out_ready = 1'b1;
    tick();
    mul_if.out_ready = 1'b0;
    check({name, " out_valid after take"}, 64'(mul_if.out_valid), 64'd0);
    check({name, " in_ready after take"}, 64'(mul_if.in_ready), 64'd1);
    check({name, " Z kept in idle"}, 64'(mul_if.Z), 64'(exp));
  endtask

  initial begin
    vec_t vecs[10];
    int lat, busy_cnt, gap;
    logic [W-1:0] rm, rq;

    vecs[0] = '{16'd7,      16'hFFFD, 32'hFFFF_FFEB};
    vecs[1] = '{16'h8000,   16'h8000, 32'h4000_0000};
    vecs[2] = '{16'h8000,   16'd1,    32'hFFFF_8000};
    vecs[3] = '{16'd3,      16'd5,    32'd15};
    vecs[4] = '{16'hFFFC,   16'd6,    32'hFFFF_FFE8};
    vecs[5] = '{16'd2,      16'd2,    32'd4};
    vecs[6] = '{16'd0,      16'hFFFF, 32'd0};
    vecs[7] = '{16'h7FFF,   16'h7FFF, 32'h3FFF_0001};
    vecs[8] = '{16'hFFFF,   16'hFFFF, 32'd1};
    vecs[9] = '{16'h7FFF,   16'h8000, 32'hC000_8000};

    mul_if.in_valid  = 1'b0;
    mul_if.out_ready = 1'b0;
    mul_if.M = '0;
    mul_if.Q = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset in_ready", 64'(mul_if.in_ready), 64'd1);
    check("reset out_valid", 64'(mul_if.out_valid), 64'd0);
    check("reset busy", 64'(mul_if.busy), 64'd0);
    check("reset Z", 64'(mul_if.Z), 64'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].m, vecs[i].q, vecs[i].z, 1'b0, $sformatf("vec%0d", i));
      take((i == 0) ? 5 : 0, vecs[i].z, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      rm = 16'($urandom);
      rq = 16'($urandom);
      run_op(rm, rq, ref_mul(rm, rq), 1'b0, $sformatf("rand%0d", i));
      take(int'($urandom_range(0, 3)), ref_mul(rm, rq), $sformatf("rand%0d", i));
    end

    // in_valid pulses during RUN must be ignored
    run_op(16'd7, 16'hFFFD, 32'hFFFF_FFEB, 1'b1, "ignore in RUN");
    take(0, 32'hFFFF_FFEB, "ignore in RUN");

    // Back-to-back: second operands accepted on the DONE edge, no IDLE bubble
    mul_if.M = 16'd3;
    mul_if.Q = 16'd5;
    mul_if.in_valid = 1'b1;
    mul_if.out_ready = 1'b1;
    tick();
    mul_if.M = 16'hFFFC;
    mul_if.Q = 16'd6;
    wait_done(1'b0, lat, busy_cnt);
    check("b2b first latency", 64'(lat), 64'(W));
    check("b2b first Z", 64'(mul_if.Z), 64'd15);
    tick();
    check("b2b accepted in DONE", 64'(mul_if.busy), 64'd1);
    wait_done(1'b0, gap, busy_cnt);
    check("b2b product spacing", 64'(gap + 1), 64'(W + 1));
    check("b2b second Z", 64'(mul_if.Z), 64'hFFFF_FFE8);
    mul_if.in_valid = 1'b0;
    tick();
    mul_if.out_ready = 1'b0;
    check("b2b idle after take", 64'(mul_if.in_ready), 64'd1);
    check("b2b out_valid dropped", 64'(mul_if.out_valid), 64'd0);

    // Reset in the 8th RUN cycle discards the operation and clears Z
    mul_if.M = 16'd7;
    mul_if.Q = 16'hFFFD;
    mul_if.in_valid = 1'b1;
    tick();
    mul_if.in_valid = 1'b0;
    repeat (7) tick();
    check("pre-reset busy", 64'(mul_if.busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-run reset out_valid", 64'(mul_if.out_valid), 64'd0);
    check("mid-run reset busy", 64'(mul_if.busy), 64'd0);
    check("mid-run reset in_ready", 64'(mul_if.in_ready), 64'd1);
    check("mid-run reset Z", 64'(mul_if.Z), 64'd0);
    run_op(16'd2, 16'd2, 32'd4, 1'b0, "after reset");
    take(1, 32'd4, "after reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
